// File: rtl/br_pdc.sv
`default_nettype none
// ============================================================================
// Module   : br_pdc
// Brief    : Fetch-stage branch predictor. Direct-mapped BTB with per-entry
//            2-bit saturating counters; predicts the next fetch address for a
//            two-slot, 8-byte fetch group and emits a 64-bit prediction word
//            per slot. Trained from the execute-stage resolution port.
// Revision : 1.0 - initial release
// ============================================================================
module br_pdc #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic        fetch_stall,
    input  logic        fetch_flush,
    input  logic [31:0] fetch_pc,
    output logic        pred_valid,
    output logic [31:0] pred_npc,
    output logic [63:0] pre0,
    output logic [63:0] pre1,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_uncond,
    input  logic [31:0] upd_target
);

    localparam int DEPTH = 1 << IDX_W;

    // BTB storage, kept in flops so reset can clear every entry in one cycle
    logic             r_valid [DEPTH];
    logic [TAG_W-1:0] r_tag   [DEPTH];
    logic [29:0]      r_tgt   [DEPTH];
    logic [1:0]       r_ctr   [DEPTH];

    // ------------------------------------------------------------------
    // Lookup side: both slots of the group read the table in parallel
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_idx  [2];
    logic [63:0]      w_word [2];
    logic [1:0]       w_en;
    logic [1:0]       w_hit;
    logic [1:0]       w_tkn;
    logic [1:0]       w_own;
    logic [TAG_W-1:0] w_ftag;
    logic [31:0]      w_seq_npc;
    logic [31:0]      w_npc;

    // Both slots share every pc bit above bit 2, so they share the tag
    assign w_ftag    = fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_seq_npc = {fetch_pc[31:3] + 29'd1, 3'b000};

    // Slot 0 owns the redirect whenever it is taken; slot 1 only otherwise
    assign w_own = {w_tkn[1] & ~w_tkn[0], w_tkn[0]};

    generate
        for (genvar s = 0; s < 2; s++) begin : g_slot
            localparam logic c_slot_bit = (s == 1) ? 1'b1 : 1'b0;

            // Slot pc bit 2 is the slot number; the rest comes from fetch_pc
            assign w_idx[s] = {fetch_pc[IDX_W+1:3], c_slot_bit};

            // A fetch entering mid-group (pc[2]=1) skips slot 0
            if (s == 0) begin : g_en0
                assign w_en[s] = ~fetch_pc[2];
            end else begin : g_en1
                assign w_en[s] = 1'b1;
            end

            assign w_hit[s] = w_en[s] & r_valid[w_idx[s]]
                            & (r_tag[w_idx[s]] == w_ftag);
            assign w_tkn[s] = w_hit[s] & r_ctr[w_idx[s]][1];

            assign w_word[s] = w_en[s] ?
                {27'd0, w_hit[s], w_own[s], r_ctr[w_idx[s]], w_tkn[s],
                 (w_hit[s] ? {r_tgt[w_idx[s]], 2'b00} : 32'd0)} : 64'd0;
        end
    endgenerate

    assign w_npc = w_tkn[0] ? {r_tgt[w_idx[0]], 2'b00} :
                   w_tkn[1] ? {r_tgt[w_idx[1]], 2'b00} : w_seq_npc;

    // ------------------------------------------------------------------
    // Update side: read-modify-write of the entry addressed by upd_pc
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_uhit;
    logic [1:0]       w_uctr;
    logic [1:0]       w_nctr;

    assign w_uidx = upd_pc[IDX_W+1:2];
    assign w_utag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_uhit = r_valid[w_uidx] & (r_tag[w_uidx] == w_utag);
    assign w_uctr = r_ctr[w_uidx];

    // Next counter value for a hit: jumps pin to strongly taken, branches saturate
    always_comb begin
        w_nctr = w_uctr;
        if (upd_uncond) begin
            w_nctr = 2'b11;
        end else if (upd_taken) begin
            if (w_uctr != 2'b11) w_nctr = w_uctr + 2'd1;
        end else begin
            if (w_uctr != 2'b00) w_nctr = w_uctr - 2'd1;
        end
    end

    // Table write; lookups this cycle still see the pre-update contents
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else if (upd_valid) begin
            if (w_uhit) begin
                r_ctr[w_uidx] <= w_nctr;
                if (upd_taken) r_tgt[w_uidx] <= upd_target[31:2];
            end else if (upd_taken) begin
                r_valid[w_uidx] <= 1'b1;
                r_tag[w_uidx]   <= w_utag;
                r_tgt[w_uidx]   <= upd_target[31:2];
                r_ctr[w_uidx]   <= upd_uncond ? 2'b11 : 2'b10;
            end
        end
    end

    // Registered prediction outputs: flush beats stall, stall holds everything
    always_ff @(posedge clk) begin
        if (rst || fetch_flush) begin
            pred_valid <= 1'b0;
            pred_npc   <= 32'd0;
            pre0       <= 64'd0;
            pre1       <= 64'd0;
        end else if (!fetch_stall) begin
            pred_valid <= fetch_valid;
            pred_npc   <= fetch_valid ? w_npc     : 32'd0;
            pre0       <= fetch_valid ? w_word[0] : 64'd0;
            pre1       <= fetch_valid ? w_word[1] : 64'd0;
        end
    end

    // Address bits below word alignment and above the tag carry no information
    logic w_unused;
    assign w_unused = ^{fetch_pc[1:0], upd_pc[1:0], upd_pc[31:IDX_W+TAG_W+2],
                        upd_target[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_br_pdc.sv
`default_nettype none
// ============================================================================
// Module   : tb_br_pdc
// Brief    : Self-checking bench for br_pdc: directed scenarios with literal
//            expectations plus randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_br_pdc;

    localparam int IDX_W = 6;
    localparam int TAG_W = 10;
    localparam int DEPTH = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic        fetch_stall = 1'b0;
    logic        fetch_flush = 1'b0;
    logic [31:0] fetch_pc = 32'd0;
    logic        pred_valid;
    logic [31:0] pred_npc;
    logic [63:0] pre0;
    logic [63:0] pre1;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'd0;
    logic        upd_taken = 1'b0;
    logic        upd_uncond = 1'b0;
    logic [31:0] upd_target = 32'd0;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    br_pdc #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_stall(fetch_stall),
        .fetch_flush(fetch_flush), .fetch_pc(fetch_pc),
        .pred_valid(pred_valid), .pred_npc(pred_npc),
        .pre0(pre0), .pre1(pre1),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_uncond(upd_uncond), .upd_target(upd_target)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_valid [DEPTH];
    int unsigned m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];   // full byte address of the target
    int          m_ctr   [DEPTH];

    logic        exp_valid = 1'b0;
    logic [31:0] exp_npc   = 32'd0;
    logic [63:0] exp_pre0  = 64'd0;
    logic [63:0] exp_pre1  = 64'd0;

    function automatic void model_lookup(input logic [31:0] pc,
                                         output logic [31:0] npc,
                                         output logic [63:0] w0,
                                         output logic [63:0] w1);
        logic [63:0] w [2];
        bit          tk [2];
        logic [31:0] tg [2];
        logic [31:0] base;
        base = pc & 32'hFFFF_FFF8;
        for (int s = 0; s < 2; s++) begin
            logic [31:0] spc;
            int unsigned idx, tag;
            bit hit;
            spc = base + 32'(4 * s);
            idx = (spc >> 2) % DEPTH;
            tag = (spc >> (IDX_W + 2)) % (1 << TAG_W);
            hit = m_valid[idx] && (m_tag[idx] == tag);
            tk[s] = hit && (m_ctr[idx] >= 2);
            tg[s] = m_tgt[idx];
            if (s == 0 && pc[2]) begin
                w[s] = 64'd0;
                tk[s] = 1'b0;
            end else begin
                w[s] = (hit ? 64'(m_tgt[idx]) : 64'd0)
                     | (64'(tk[s]) << 32)
                     | (64'(m_ctr[idx]) << 33)
                     | (64'(hit) << 36);
            end
        end
        if (tk[0]) begin
            npc = tg[0];
            w[0] = w[0] | (64'd1 << 35);
        end else if (tk[1]) begin
            npc = tg[1];
            w[1] = w[1] | (64'd1 << 35);
        end else begin
            npc = base + 32'd8;
        end
        w0 = w[0];
        w1 = w[1];
    endfunction

    // Model steps on the same edge as the DUT: lookup sees old table, then train
    always @(posedge clk) begin
        if (rst) begin
            exp_valid = 1'b0; exp_npc = 32'd0; exp_pre0 = 64'd0; exp_pre1 = 64'd0;
            for (int i = 0; i < DEPTH; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
        end else begin
            if (fetch_flush) begin
                exp_valid = 1'b0; exp_npc = 32'd0; exp_pre0 = 64'd0; exp_pre1 = 64'd0;
            end else if (!fetch_stall) begin
                exp_valid = fetch_valid;
                if (fetch_valid) model_lookup(fetch_pc, exp_npc, exp_pre0, exp_pre1);
            end
            if (upd_valid) begin
                int unsigned idx, tag;
                idx = (upd_pc >> 2) % DEPTH;
                tag = (upd_pc >> (IDX_W + 2)) % (1 << TAG_W);
                if (m_valid[idx] && m_tag[idx] == tag) begin
                    if (upd_uncond)     m_ctr[idx] = 3;
                    else if (upd_taken) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                    else                m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
                    if (upd_taken) m_tgt[idx] = upd_target & 32'hFFFF_FFFC;
                end else if (upd_taken) begin
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = tag;
                    m_tgt[idx]   = upd_target & 32'hFFFF_FFFC;
                    m_ctr[idx]   = upd_uncond ? 3 : 2;
                end
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle away from the edge
    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (pred_valid !== exp_valid) begin
                errors++;
                $display("FAIL model_pred_valid t=%0t got=%b exp=%b", $time, pred_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (pred_npc !== exp_npc || pre0 !== exp_pre0 || pre1 !== exp_pre1) begin
                    errors++;
                    $display("FAIL model_outputs t=%0t npc got=%h exp=%h pre0 got=%h exp=%h pre1 got=%h exp=%h",
                             $time, pred_npc, exp_npc, pre0, exp_pre0, pre1, exp_pre1);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        fetch_valid = 1'b0; fetch_stall = 1'b0; fetch_flush = 1'b0;
        upd_valid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        idle();
        fetch_valid = 1'b1;
        fetch_pc = pc;
        tick();
    endtask

    task automatic train(input logic [31:0] pc, input logic tk, input logic un,
                         input logic [31:0] tgt);
        idle();
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_uncond = un; upd_target = tgt;
        tick();
        upd_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 3))
            0, 1:    rand_pc = 32'h1000 + 32'(4 * $urandom_range(0, 31));
            2:       rand_pc = 32'h5000 + 32'(4 * $urandom_range(0, 31));
            default: rand_pc = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        chk_on = 1'b1;
        tick();
        chk("reset_valid", 64'(pred_valid), 64'd0);
        rst = 1'b0;
        idle();
        tick();
        chk("post_reset_valid", 64'(pred_valid), 64'd0);

        // Empty table: sequential npc, only the counter field is nonzero
        fetch(32'h1000);
        chk("empty_valid", 64'(pred_valid), 64'd1);
        chk("empty_npc", 64'(pred_npc), 64'h1008);
        chk("empty_pre0", pre0, 64'h0000_0002_0000_0000);
        chk("empty_pre1", pre1, 64'h0000_0002_0000_0000);

        // Allocate slot 1, observe redirect through it
        train(32'h1004, 1'b1, 1'b0, 32'h2000);
        idle();
        tick();
        fetch(32'h1000);
        chk("slot1_npc", 64'(pred_npc), 64'h2000);
        chk("slot1_pre1", pre1, 64'h0000_001D_0000_2000);
        chk("slot1_pre0", pre0, 64'h0000_0002_0000_0000);

        // Collision: same-cycle lookup sees the old entry, next cycle sees new
        idle();
        fetch_valid = 1'b1; fetch_pc = 32'h1000;
        upd_valid = 1'b1; upd_pc = 32'h1000; upd_taken = 1'b1; upd_uncond = 1'b0;
        upd_target = 32'h3000;
        tick();
        chk("collide_old_npc", 64'(pred_npc), 64'h2000);
        fetch(32'h1000);
        chk("both_taken_npc", 64'(pred_npc), 64'h3000);
        chk("both_taken_pre0", pre0, 64'h0000_001D_0000_3000);
        chk("both_taken_pre1", pre1, 64'h0000_0015_0000_2000);

        // Mid-group entry disables slot 0
        fetch(32'h1004);
        chk("midgroup_pre0", pre0, 64'd0);
        chk("midgroup_npc", 64'(pred_npc), 64'h2000);
        chk("midgroup_pre1", pre1, 64'h0000_001D_0000_2000);

        // Counter training on 0x1000 (currently 10)
        train(32'h1000, 1'b1, 1'b0, 32'h3000); fetch(32'h1000);
        chk("ctr_t1", 64'(pre0[34:33]), 64'd3);
        train(32'h1000, 1'b1, 1'b0, 32'h3000); fetch(32'h1000);
        chk("ctr_t2", 64'(pre0[34:33]), 64'd3);
        train(32'h1000, 1'b0, 1'b0, 32'h0);    fetch(32'h1000);
        chk("ctr_n1", 64'(pre0[34:33]), 64'd2);
        train(32'h1000, 1'b0, 1'b0, 32'h0);    fetch(32'h1000);
        chk("ctr_n2", 64'(pre0[34:33]), 64'd1);
        train(32'h1000, 1'b0, 1'b0, 32'h0);    fetch(32'h1000);
        chk("ctr_n3", 64'(pre0[34:33]), 64'd0);
        chk("ctr_n3_hit", 64'(pre0[36]), 64'd1);
        chk("ctr_n3_taken", 64'(pre0[32]), 64'd0);
        chk("ctr_n3_npc", 64'(pred_npc), 64'h2000);

        // Stall with a changing pc holds the 0x1000 prediction
        fetch(32'h1000);
        fetch_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_pc = 32'h1100 + 32'(8 * i);
            tick();
            chk("stall_npc", 64'(pred_npc), 64'h2000);
        end
        fetch_flush = 1'b1;
        tick();
        chk("flush_in_stall", 64'(pred_valid), 64'd0);
        idle();

        // npc increment wraps at the top of the address space
        fetch(32'hFFFF_FFF8);
        chk("wrap_npc", 64'(pred_npc), 64'd0);

        // Randomized traffic, checked every cycle by the model compare
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 199) == 0);
            fetch_valid = ($urandom_range(0, 3) != 0);
            fetch_stall = ($urandom_range(0, 4) == 0);
            fetch_flush = ($urandom_range(0, 9) == 0);
            fetch_pc    = rand_pc();
            upd_valid   = ($urandom_range(0, 1) == 0);
            upd_pc      = rand_pc();
            upd_taken   = ($urandom_range(0, 2) != 0);
            upd_uncond  = ($urandom_range(0, 4) == 0);
            upd_target  = $urandom() & 32'hFFFF_FFFC;
            tick();
        end

        // Reset mid-stream with an update pending: outputs clear, table empties
        idle();
        rst = 1'b0;
        train(32'h1000, 1'b1, 1'b0, 32'h3000);
        fetch_valid = 1'b1; fetch_pc = 32'h1000;
        upd_valid = 1'b1; upd_pc = 32'h1008; upd_taken = 1'b1; upd_target = 32'h7000;
        rst = 1'b1;
        tick();
        chk("rst_valid", 64'(pred_valid), 64'd0);
        chk("rst_npc", 64'(pred_npc), 64'd0);
        chk("rst_pre0", pre0, 64'd0);
        rst = 1'b0;
        idle();
        tick();
        fetch(32'h1000);
        chk("rst_refetch_npc", 64'(pred_npc), 64'h1008);
        chk("rst_refetch_hit", 64'(pre0[36]), 64'd0);
        fetch(32'h1008);
        chk("rst_dropped_upd", 64'(pre0[36]), 64'd0);
        idle();
        tick();

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
